// File: rtl/writeback_sel_pipe_if.sv
// writeback_sel_pipe_if: instruction/operand inputs, external-input handshake
// and the valid/ready write-back output of the write-back selector.
interface writeback_sel_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       order;
    logic [WIDTH-1:0] bc;
    logic [WIDTH-1:0] add;
    logic [WIDTH-1:0] subc;
    logic [WIDTH-1:0] reg_src;
    logic [WIDTH-1:0] ext;
    logic             ext_valid;
    logic             ext_ack;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] wb_data;
    logic [2:0]       out_src;
    logic             out_err;

    // Upstream / register-file side: drives instructions, operands and EXT
    modport master (
        output in_valid, order, bc, add, subc, reg_src, ext, ext_valid, out_ready,
        input  in_ready, ext_ack, out_valid, wb_data, out_src, out_err
    );

    // Selector side
    modport slave (
        input  in_valid, order, bc, add, subc, reg_src, ext, ext_valid, out_ready,
        output in_ready, ext_ack, out_valid, wb_data, out_src, out_err
    );
endinterface

// File: rtl/writeback_sel_pipe.sv
// writeback_sel_pipe: registered write-back data selector. Decodes the 8-bit
// instruction, picks the result source, and holds it in a valid/ready output
// stage. External-input instructions stall on ext_valid/ext_ack, with an
// optional timeout that completes with an error and zero data.
module writeback_sel_pipe #(
    parameter int WIDTH       = 4,
    parameter int EXT_TIMEOUT = 0
) (
    input logic                clk,
    input logic                reset,
    writeback_sel_pipe_if.slave bus
);

    localparam int CW = (EXT_TIMEOUT == 0) ? 1 : $clog2(EXT_TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(EXT_TIMEOUT);

    localparam logic [2:0] SRC_BC   = 3'd0;
    localparam logic [2:0] SRC_ADD  = 3'd1;
    localparam logic [2:0] SRC_SUBC = 3'd2;
    localparam logic [2:0] SRC_EXT  = 3'd3;
    localparam logic [2:0] SRC_REG  = 3'd4;
    localparam logic [2:0] SRC_IMM  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EXT,
        HOLD
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [2:0]       src_q, src_n;
    logic             err_q, err_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [CW-1:0]    cnt_inc;

    logic             dec_ext;
    logic [2:0]       dec_src;
    logic [WIDTH-1:0] sel_data;
    logic             accept;

    assign bus.in_ready  = (state == IDLE) | ((state == HOLD) & bus.out_ready);
    assign bus.ext_ack   = (state == WAIT_EXT) & bus.ext_valid;
    assign bus.out_valid = (state == HOLD);
    assign bus.wb_data   = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_err   = err_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign cnt_inc = cnt_q + 1'b1;

    // Decode the opcode into a source code and pick the matching operand
    always_comb begin
        dec_ext  = 1'b0;
        dec_src  = SRC_BC;
        sel_data = '0;
        case (bus.order[7:6])
            2'b11: dec_src = SRC_REG;
            2'b10: dec_src = SRC_IMM;
            2'b00: dec_src = SRC_BC;
            default: begin
                if (!bus.order[5]) begin
                    dec_src = SRC_ADD;
                end else if (!bus.order[4]) begin
                    dec_src = SRC_SUBC;
                end else if (!bus.order[3]) begin
                    dec_src = SRC_EXT;
                    dec_ext = 1'b1;
                end else begin
                    dec_src = SRC_REG;
                end
            end
        endcase
        case (dec_src)
            SRC_BC:   sel_data = bus.bc;
            SRC_ADD:  sel_data = bus.add;
            SRC_SUBC: sel_data = bus.subc;
            SRC_REG:  sel_data = bus.reg_src;
            SRC_IMM:  sel_data = WIDTH'(bus.order[5:2]);
            default:  sel_data = '0;
        endcase
    end

    // Next-state and next-result logic; results only change on a load or EXT completion
    always_comb begin
        state_n = state;
        data_n  = data_q;
        src_n   = src_q;
        err_n   = err_q;
        cnt_n   = cnt_q;
        case (state)
            WAIT_EXT: begin
                if (bus.ext_valid) begin
                    state_n = HOLD;
                    data_n  = bus.ext;
                    src_n   = SRC_EXT;
                    err_n   = 1'b0;
                end else if (EXT_TIMEOUT != 0) begin
                    if (cnt_q < TMAX) begin
                        cnt_n = cnt_inc;
                    end
                    if (cnt_inc >= TMAX) begin
                        state_n = HOLD;
                        data_n  = '0;
                        src_n   = SRC_EXT;
                        err_n   = 1'b1;
                    end
                end
            end
            default: begin
                if ((state == HOLD) && bus.out_ready) begin
                    state_n = IDLE;
                end
                if (accept) begin
                    if (dec_ext) begin
                        state_n = WAIT_EXT;
                        cnt_n   = '0;
                    end else begin
                        state_n = HOLD;
                        data_n  = sel_data;
                        src_n   = dec_src;
                        err_n   = 1'b0;
                    end
                end
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            data_q <= '0;
            src_q  <= SRC_BC;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            src_q  <= src_n;
            err_q  <= err_n;
            cnt_q  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_writeback_sel_pipe.sv
// tb_writeback_sel_pipe: directed checks of the write-back selector.
// busA/dutA: WIDTH=4, no timeout. busB/dutB: WIDTH=8. busC/dutC: WIDTH=4, EXT_TIMEOUT=4.
module tb_writeback_sel_pipe;

    logic clk;
    logic reset;
    int   passCount;
    int   checkCount;

    writeback_sel_pipe_if #(.WIDTH(4)) busA ();
    writeback_sel_pipe_if #(.WIDTH(8)) busB ();
    writeback_sel_pipe_if #(.WIDTH(4)) busC ();

    writeback_sel_pipe #(.WIDTH(4), .EXT_TIMEOUT(0)) dutA (.clk(clk), .reset(reset), .bus(busA));
    writeback_sel_pipe #(.WIDTH(8), .EXT_TIMEOUT(0)) dutB (.clk(clk), .reset(reset), .bus(busB));
    writeback_sel_pipe #(.WIDTH(4), .EXT_TIMEOUT(4)) dutC (.clk(clk), .reset(reset), .bus(busC));

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] order, input logic [3:0] regv);
        busA.in_valid = 1'b1;
        busA.order    = order;
        busA.reg_src  = regv;
    endtask

    // Directed stimulus sequence
    initial begin
        logic [7:0] vOrder [6];
        logic [3:0] vReg   [6];
        logic [3:0] vData  [6];
        logic [2:0] vSrc   [6];
        vOrder = '{8'h00, 8'h40, 8'h60, 8'h78, 8'hB4, 8'hC0};
        vReg   = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h7};
        vData  = '{4'h5, 4'hA, 4'h3, 4'h9, 4'hD, 4'h7};
        vSrc   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd4};
        passCount  = 0;
        checkCount = 0;

        busA.in_valid = 0; busA.order = 0; busA.bc = 4'h5; busA.add = 4'hA;
        busA.subc = 4'h3; busA.reg_src = 4'h9; busA.ext = 0; busA.ext_valid = 0; busA.out_ready = 1;
        busB.in_valid = 0; busB.order = 0; busB.bc = 8'h55; busB.add = 8'hAA;
        busB.subc = 8'h33; busB.reg_src = 8'h99; busB.ext = 0; busB.ext_valid = 0; busB.out_ready = 1;
        busC.in_valid = 0; busC.order = 0; busC.bc = 4'h5; busC.add = 4'hA;
        busC.subc = 4'h3; busC.reg_src = 4'h9; busC.ext = 4'hE; busC.ext_valid = 0; busC.out_ready = 1;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_out_valid", busA.out_valid, 0);
        checkOutput("rst_data", busA.wb_data, 0);
        checkOutput("rst_src", busA.out_src, 0);
        checkOutput("rst_err", busA.out_err, 0);
        checkOutput("rst_in_ready", busA.in_ready, 1);
        checkOutput("rst_ext_ack", busA.ext_ack, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vOrder[i], vReg[i]);
            tick();
            checkOutput($sformatf("src%0d_valid", i), busA.out_valid, 1);
            checkOutput($sformatf("src%0d_data", i), busA.wb_data, 32'(vData[i]));
            checkOutput($sformatf("src%0d_src", i), busA.out_src, 32'(vSrc[i]));
            checkOutput($sformatf("src%0d_err", i), busA.out_err, 0);
        end
        busA.in_valid = 0;
        tick();
        checkOutput("drain_valid", busA.out_valid, 0);

        busB.in_valid = 1; busB.order = 8'hBC;
        tick();
        busB.in_valid = 0;
        checkOutput("w8_imm_valid", busB.out_valid, 1);
        checkOutput("w8_imm_data", busB.wb_data, 32'h0F);
        checkOutput("w8_imm_src", busB.out_src, 5);

        busA.in_valid = 1; busA.order = 8'h70; busA.ext = 4'hC;
        tick();
        busA.in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("ext_wait%0d_in_ready", i), busA.in_ready, 0);
            checkOutput($sformatf("ext_wait%0d_ack", i), busA.ext_ack, 0);
            checkOutput($sformatf("ext_wait%0d_valid", i), busA.out_valid, 0);
            tick();
        end
        busA.ext_valid = 1;
        #1;
        checkOutput("ext_ack_high", busA.ext_ack, 1);
        checkOutput("ext_ack_in_ready", busA.in_ready, 0);
        tick();
        busA.ext_valid = 0;
        checkOutput("ext_done_ack", busA.ext_ack, 0);
        checkOutput("ext_done_valid", busA.out_valid, 1);
        checkOutput("ext_done_data", busA.wb_data, 32'hC);
        checkOutput("ext_done_src", busA.out_src, 3);
        checkOutput("ext_done_err", busA.out_err, 0);
        tick();

        busC.in_valid = 1; busC.order = 8'h70;
        tick();
        busC.in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("to_wait%0d_valid", i), busC.out_valid, 0);
            checkOutput($sformatf("to_wait%0d_ack", i), busC.ext_ack, 0);
            tick();
        end
        checkOutput("to_valid", busC.out_valid, 1);
        checkOutput("to_data", busC.wb_data, 0);
        checkOutput("to_src", busC.out_src, 3);
        checkOutput("to_err", busC.out_err, 1);
        tick();
        checkOutput("to_idle", busC.out_valid, 0);

        busC.in_valid = 1; busC.order = 8'h70; busC.ext = 4'h6;
        tick();
        busC.in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("race_wait%0d_valid", i), busC.out_valid, 0);
            tick();
        end
        busC.ext_valid = 1;
        #1;
        checkOutput("race_ack", busC.ext_ack, 1);
        tick();
        busC.ext_valid = 0;
        checkOutput("race_valid", busC.out_valid, 1);
        checkOutput("race_data", busC.wb_data, 32'h6);
        checkOutput("race_err", busC.out_err, 0);
        tick();

        busA.out_ready = 0;
        applyStimulus(8'h00, 4'h9);
        tick();
        busA.order = 8'h40;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d_in_ready", i), busA.in_ready, 0);
            checkOutput($sformatf("bp%0d_valid", i), busA.out_valid, 1);
            checkOutput($sformatf("bp%0d_data", i), busA.wb_data, 32'h5);
            tick();
        end
        busA.out_ready = 1;
        #1;
        checkOutput("bp_release_in_ready", busA.in_ready, 1);
        tick();
        busA.in_valid = 0;
        checkOutput("bp_b2b_valid", busA.out_valid, 1);
        checkOutput("bp_b2b_data", busA.wb_data, 32'hA);
        checkOutput("bp_b2b_src", busA.out_src, 1);
        tick();

        applyStimulus(8'h70, 4'h9);
        tick();
        busA.in_valid = 0;
        tick();
        reset = 1; busA.ext_valid = 1;
        tick();
        reset = 0;
        checkOutput("rst_wait_valid", busA.out_valid, 0);
        checkOutput("rst_wait_data", busA.wb_data, 0);
        checkOutput("rst_wait_in_ready", busA.in_ready, 1);
        checkOutput("rst_wait_ack", busA.ext_ack, 0);
        busA.ext_valid = 0;

        busA.out_ready = 0;
        applyStimulus(8'hC0, 4'h7);
        tick();
        busA.in_valid = 0;
        checkOutput("pre_rst_hold_data", busA.wb_data, 32'h7);
        reset = 1;
        tick();
        reset = 0;
        checkOutput("rst_hold_valid", busA.out_valid, 0);
        checkOutput("rst_hold_data", busA.wb_data, 0);
        checkOutput("rst_hold_src", busA.out_src, 0);
        checkOutput("rst_hold_in_ready", busA.in_ready, 1);
        checkOutput("rst_hold_ack", busA.ext_ack, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/writeback_sel_pipe.md
# writeback_sel_pipe

Registered, handshaked successor to the combinational register write-data selector of the TPU datapath. It decodes the 8-bit instruction, selects the write-back value from the bit-op, adder, sub-op, external-input or register source, or from the immediate field, and presents it to the register file through a valid/ready output stage. Width is parametrised. External-input instructions stall on an EXT_VALID/EXT_ACK handshake with an optional timeout.

## Interface
- WIDTH, default 4: data width of all operand and result ports; must be ≥ 4.
- EXT_TIMEOUT, default 0: maximum WAIT_EXT cycles without EXT_VALID before an error completion; 0 disables the timeout.
- CLK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  an instruction and its operands are presented.
- IN_READY  out  1  block accepts the instruction this cycle.
- ORDER  in  8  instruction opcode.
- BC, ADD, SUBC, REG  in  WIDTH each  candidate source values: bit-op, add, sub-op, register.
- EXT  in  WIDTH  external input data.
- EXT_VALID  in  1  EXT holds valid data.
- EXT_ACK  out  1  block consumes EXT this cycle.
- OUT_VALID  out  1  OUTPUT is valid.
- OUT_READY  in  1  register file takes OUTPUT.
- OUTPUT  out  WIDTH  selected write-back data.
- OUT_SRC  out  3  source code: 0 BC, 1 ADD, 2 SUBC, 3 EXT, 4 REG, 5 IMM.
- OUT_ERR  out  1  external-input timeout; OUTPUT is 0.

## Operation
- Decode on ORDER, evaluated at accept:
  - ORDER[7:6]=11 → REG.
  - ORDER[7:6]=10 → IMM, ORDER[5:2] zero-extended to WIDTH.
  - ORDER[7:6]=00 → BC.
  - ORDER[7:6]=01 with ORDER[5]=0 → ADD.
  - ORDER[7:6]=01 with ORDER[5:4]=10 → SUBC.
  - ORDER[7:3]=01110 → EXT.
  - ORDER[7:3]=01111 → REG.
- States:
  - IDLE: no result held.
  - WAIT_EXT: waiting for external data.
  - HOLD: OUT_VALID high, result held.
- Accept = IN_VALID & IN_READY.
- IN_READY = (state==IDLE) | (state==HOLD & OUT_READY).
- On accept of a non-EXT instruction:
  - OUTPUT ← selected value, captured from that cycle's inputs.
  - OUT_SRC ← source code; OUT_ERR ← 0; go to HOLD.
- On accept of an EXT instruction: go to WAIT_EXT and clear the timeout counter.
- EXT_ACK = (state==WAIT_EXT) & EXT_VALID, combinational.
- In WAIT_EXT:
  - If EXT_VALID: OUTPUT ← EXT, OUT_SRC ← 3, OUT_ERR ← 0, go to HOLD.
  - Else, if EXT_TIMEOUT≠0: increment the counter. When it reaches EXT_TIMEOUT, OUTPUT ← 0, OUT_SRC ← 3, OUT_ERR ← 1, go to HOLD.
  - EXT_VALID wins over timeout when both occur in the same cycle.
- In HOLD:
  - OUTPUT, OUT_SRC and OUT_ERR are held stable until OUT_READY.
  - OUT_READY with no accept → IDLE.
  - OUT_READY with a same-cycle accept → load the new instruction (HOLD or WAIT_EXT).
- Counter width is ⌈log2(EXT_TIMEOUT+1)⌉, minimum 1. The counter saturates and never wraps.
- IN_VALID while not ready has no effect; the upstream stage holds ORDER and operands.

## Timing
- RESET, any state, any cycle: next cycle state=IDLE, OUT_VALID=0, OUTPUT=0, OUT_SRC=0, OUT_ERR=0, counter=0, EXT_ACK=0, IN_READY=1. A pending EXT is abandoned with no ack.
- Non-EXT latency: accept at edge N → OUT_VALID=1 after edge N.
- EXT latency: OUT_VALID rises the cycle after the EXT_ACK cycle.
- Timeout: OUT_VALID rises EXT_TIMEOUT cycles after WAIT_EXT entry, when EXT_VALID stays low throughout.
- Throughput: one result per cycle while OUT_READY=1 and no EXT stall. No bubble on back-to-back transfers.
- EXT_ACK is high for exactly one cycle per EXT instruction, or never if the instruction times out.

## Test plan
- Reset, then per-source accept check, WIDTH=4:
  - ORDER=0x00, BC=0x5 → OUTPUT=0x5, SRC=0.
  - ORDER=0x40, ADD=0xA → 0xA, SRC=1.
  - ORDER=0x60, SUBC=0x3 → 0x3, SRC=2.
  - ORDER=0x78, REG=0x9 → 0x9, SRC=4.
  - ORDER=0xB4 → 0xD, SRC=5.
  - ORDER=0xC0, REG=0x7 → 0x7, SRC=4.
  - Each completes one cycle after accept.
- WIDTH=8 immediate: ORDER=0xBC → OUTPUT=0x0F, zero-extended.
- EXT path: ORDER=0x70, EXT_VALID low 3 cycles, then high with EXT=0xC → EXT_ACK high in exactly that one cycle; next cycle OUTPUT=0xC, SRC=3, ERR=0; IN_READY=0 throughout WAIT_EXT.
- Timeout, EXT_TIMEOUT=4: ORDER=0x70 with EXT_VALID never high → after 4 WAIT_EXT cycles OUT_VALID=1, OUTPUT=0, ERR=1, no EXT_ACK. Repeat with EXT_VALID rising on the 4th cycle → EXT data wins, ERR=0.
- Backpressure: OUT_READY=0 for 5 cycles while IN_VALID is held → OUTPUT stable and IN_READY=0. Release OUT_READY with IN_VALID high → back-to-back transfer with no bubble, new result the next cycle.
- Reset mid-WAIT_EXT and mid-HOLD → next cycle OUT_VALID=0, OUTPUT=0, IN_READY=1, EXT_ACK=0.
